div_seq: RTL and testbench

- Multi-cycle controller and datapath for 32-bit DIV/DIVU, started by the EX stage when ID decodes EXE_DIV_OP or EXE_DIVU_OP.
- Runs a 32-iteration restoring division and returns {remainder, quotient} for the HI/LO write.
- Drives the EX stall request while busy, so the pipeline holds the divide in EX until the result is ready.

---
 rtl/div_seq_pkg.sv | 23 ++
 rtl/div_seq_step.sv | 33 +++
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
//   - FSM state encodings for the divide controller (2 bits)
//   - start/stop and result-ready control constants
//   - EX-stage decode constants for the two divide opcodes
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // ALU operation codes the ID stage hands to EX for divides.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_seq_pkg

// File: rtl/div_seq_step.sv
// One restoring-division step (combinational).
//   r      : current partial remainder (DW bits)
//   q_msb  : next dividend bit shifted into the remainder
//   d      : divisor magnitude
//   r_next : partial remainder after the trial subtract
//   q_bit  : quotient bit produced by this step
// Kept separate so the divider can later be unrolled to several
// bits per cycle by chaining instances.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] r,
  input  logic          q_msb,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);

  // The trial value is one bit wider than the divisor so a divisor with
  // its MSB set still compares correctly against the shifted remainder.
  logic [DW:0]   trial;
  logic [DW-1:0] diff;

  always_comb begin
    trial  = {r, q_msb};
    q_bit  = (trial >= {1'b0, d});
    // When the subtract is taken the true difference is below d, so the
    // low DW bits of the modular subtraction are exact.
    diff   = trial[DW-1:0] - d;
    r_next = q_bit ? diff : trial[DW-1:0];
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit for the EX stage.
// Performs a DW-iteration restoring division on operand magnitudes and
// applies the signs afterwards. Returns {remainder, quotient} for HI/LO.
//   clk, rst   : clock, synchronous active-high reset
//   signed_div : 1 = DIV, 0 = DIVU (sampled with start in IDLE)
//   opdata1    : dividend (rs)
//   opdata2    : divisor (rt)
//   start      : divide request, held until ready is seen
//   annul      : cancel; aborts any operation, wins over start
//   result     : {remainder, quotient}, registered
//   ready      : result valid, registered
//   stallreq   : combinational stall request to the pipeline controller
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div,
  input  logic [DW-1:0]   opdata1,
  input  logic [DW-1:0]   opdata2,
  input  logic            start,
  input  logic            annul,
  output logic [2*DW-1:0] result,
  output logic            ready,
  output logic            stallreq
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  div_state_e state, state_nxt;

  logic          load, step_en, finish, zero_done, clear;
  logic [DW-1:0] div_d, div_q, div_r;
  logic          sign_q, sign_r;
  logic [CW-1:0] cnt;
  logic [DW-1:0] r_next, q_next;
  logic          q_bit;
  logic          op1_neg, op2_neg;

  function automatic logic [DW-1:0] cond_neg(input logic neg, input logic [DW-1:0] v);
    logic signed [DW-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  assign op1_neg  = signed_div & opdata1[DW-1];
  assign op2_neg  = signed_div & opdata2[DW-1];
  assign q_next   = {div_q[DW-2:0], q_bit};
  assign stallreq = start & ~annul & ~ready;

  div_step #(.DW(DW)) u_step (
    .r      (div_r),
    .q_msb  (div_q[DW-1]),
    .d      (div_d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    zero_done = 1'b0;
    clear     = 1'b0;
    unique case (state)
      DivFree: begin
        if ((start == DivStart) && !annul) begin
          if (opdata2 == '0) begin
            state_nxt = DivByZero;
          end else begin
            state_nxt = DivOn;
            load      = 1'b1;
          end
        end
      end
      DivByZero: begin
        if (annul) begin
          state_nxt = DivFree;
          clear     = 1'b1;
        end else begin
          state_nxt = DivEnd;
          zero_done = 1'b1;
        end
      end
      DivOn: begin
        if (annul) begin
          state_nxt = DivFree;
          clear     = 1'b1;
        end else begin
          step_en = 1'b1;
          if (cnt == LAST) begin
            state_nxt = DivEnd;
            finish    = 1'b1;
          end
        end
      end
      DivEnd: begin
        // Leaving DONE (start dropped or annulled) clears the result.
        if ((start == DivStop) || annul) begin
          state_nxt = DivFree;
          clear     = 1'b1;
        end
      end
      default: state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_d  <= '0;
      div_q  <= '0;
      div_r  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ready  <= DivResultNotReady;
    end else begin
      if (load) begin
        div_d  <= cond_neg(op2_neg, opdata2);
        div_q  <= cond_neg(op1_neg, opdata1);
        div_r  <= '0;
        sign_q <= op1_neg ^ op2_neg;
        sign_r <= op1_neg;
        cnt    <= '0;
      end
      if (step_en) begin
        div_r <= r_next;
        div_q <= q_next;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        // Signed MIN / -1 wraps naturally: the negated magnitude is MIN.
        result <= {cond_neg(sign_r, r_next), cond_neg(sign_q, q_next)};
        ready  <= DivResultReady;
      end
      if (zero_done) begin
        result <= '0;
        ready  <= DivResultReady;
      end
      if (clear) begin
        result <= '0;
        ready  <= DivResultNotReady;
      end
    end
  end

endmodule : div_seq

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stallreq;

  int n_cmp = 0;
  int n_err = 0;

  div_seq #(.DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer division, truncating toward zero, remainder
  // taking the dividend's sign; divide by zero yields 0.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Start a divide at the next cycle, hold start through the ready cycle
  // plus 'hold' more cycles, then drop it and check the return to idle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [63:0] exp;
    int lat;
    exp = model(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 33;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_stall"}, 64'(stallreq), 64'd1);
      check({tag, "_busy_rdy"}, 64'(ready), 64'd0);
      if (k == 3) begin
        // Inputs wander during RUN; the latched operands must win.
        signed_div = 1'($urandom);
        opdata1    = $urandom;
        opdata2    = $urandom;
      end
    end
    @(negedge clk);
    check({tag, "_rdy"}, 64'(ready), 64'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_stall_rdy"}, 64'(stallreq), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      check({tag, "_hold_res"}, result, exp);
      check({tag, "_hold_stall"}, 64'(stallreq), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_drop_rdy"}, 64'(ready), 64'd1);
    check({tag, "_drop_res"}, result, exp);
    @(negedge clk);
    check({tag, "_idle_rdy"}, 64'(ready), 64'd0);
    check({tag, "_idle_res"}, result, 64'd0);
    check({tag, "_idle_stall"}, 64'(stallreq), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", 64'(ready), 64'd0);
    check("reset_res", result, 64'd0);
    check("reset_stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    check("divu_100_7_const", model(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, 0, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu_wide");
    run_div(1'b0, 32'h1234, 32'd0, 0, "div_by_zero");
    run_div(1'b1, 32'h8000_0000, 32'd0, 0, "sdiv_by_zero");
    run_div(1'b0, 32'd100, 32'd7, 3, "hold_done");

    // annul in cycle 10 of RUN, then a fresh start in cycle 12
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("annul_run_rdy", 64'(ready), 64'd0);
    end
    @(posedge clk); #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq), 64'd0);
    check("annul_rdy", 64'(ready), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    check("annul_idle_rdy", 64'(ready), 64'd0);
    check("annul_idle_res", result, 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 0, "post_annul");

    // annul while in BYZERO: no result is delivered
    @(posedge clk); #1;
    start = 1'b1; opdata1 = 32'h55; opdata2 = 32'd0;
    @(posedge clk); #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    check("annul_bz_rdy", 64'(ready), 64'd0);
    check("annul_bz_res", result, 64'd0);
    @(negedge clk);
    check("annul_bz_rdy2", 64'(ready), 64'd0);

    // rst in cycle 20 of RUN
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'hDEAD_BEEF; opdata2 = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_run_rdy", 64'(ready), 64'd0);
    check("rst_run_res", result, 64'd0);
    check("rst_run_stall", 64'(stallreq), 64'd0);
    repeat (15) begin
      @(negedge clk);
      check("rst_quiet_rdy", 64'(ready), 64'd0);
    end
    run_div(1'b1, 32'hDEAD_BEEF, 32'd3, 0, "post_rst");

    // Randomized divides against the reference
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = $urandom_range(0, 9);
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, $urandom_range(0, 1), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_div_seq
